// File: rtl/acc_cpu_param_if.sv
// Memory-side bus of the accumulator CPU: read data, ready handshake, write strobe and
// address, plus a read-only view of the core registers for checkers.
interface acc_cpu_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    // Handshake: the CPU holds mem_req, address, we and data_out stable until an edge
    // that samples mem_ready=1. That edge completes the transfer, and read data is
    // taken from data_in on it. mem_ready is ignored while mem_req=0.
    logic [DATA_W-1:0] data_in;
    logic              mem_ready;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address;
    logic              we;
    logic              mem_req;
    logic              halted;

    logic [1:0]        dbg_state;
    logic [ADDR_W-1:0] dbg_pc;
    logic [DATA_W-1:0] dbg_ir;
    logic              dbg_z;
    logic              dbg_c;

    modport master (
        input  data_in, mem_ready,
        output data_out, address, we, mem_req, halted,
        output dbg_state, dbg_pc, dbg_ir, dbg_z, dbg_c
    );

    modport slave (
        output data_in, mem_ready,
        input  data_out, address, we, mem_req, halted
    );

    modport monitor (
        input data_in, mem_ready, data_out, address, we, mem_req, halted,
        input dbg_state, dbg_pc, dbg_ir, dbg_z, dbg_c
    );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised fetch/execute accumulator CPU with a ready-based memory handshake,
// Z/C flags, conditional branches and a sticky HALT state.
module acc_cpu_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    acc_cpu_param_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SHL  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_LDI  = 4'b0100;
    localparam logic [3:0] OP_LD   = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_BR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_BZ   = 4'b1100;
    localparam logic [3:0] OP_BC   = 4'b1101;
    localparam logic [3:0] OP_RSV  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [DATA_W-1:0] ir, ir_d;
    logic [DATA_W-1:0] ac, ac_d;
    logic              z, z_d;
    logic              c, c_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] m;
    logic              is_mem_op;
    logic              exec_fire;
    logic [DATA_W:0]   add_full;
    logic [DATA_W-1:0] sub_res;
    logic              sub_borrow;
    logic [DATA_W-1:0] shl_res;
    logic [DATA_W-1:0] shr_res;
    logic [DATA_W-1:0] ac_new;
    logic              ac_wr;
    logic              unused_ir;

    assign opcode    = ir[DATA_W-1 -: 4];
    assign operand   = ir[ADDR_W-1:0];
    assign m         = bus.data_in;
    assign unused_ir = ^ir;

    always_comb begin
        is_mem_op = 1'b0;
        case (opcode)
            OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
            OP_ST, OP_AND, OP_SUB, OP_XOR: is_mem_op = 1'b1;
            default:                       is_mem_op = 1'b0;
        endcase
    end

    // Non-memory ops finish on the first execute edge; memory ops wait for mem_ready.
    assign exec_fire = (state == S_EXECUTE) && (!is_mem_op || bus.mem_ready);

    assign add_full   = {1'b0, ac} + {1'b0, m};
    assign sub_res    = ac - m;
    assign sub_borrow = (m > ac);
    assign shl_res    = (m >= SHIFT_LIMIT) ? '0 : (ac << m);
    assign shr_res    = (m >= SHIFT_LIMIT) ? '0 : (ac >> m);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            ac    <= '0;
            z     <= 1'b1;
            c     <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            ir    <= ir_d;
            ac    <= ac_d;
            z     <= z_d;
            c     <= c_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        ac_d    = ac;
        z_d     = z;
        c_d     = c;
        ac_new  = ac;
        ac_wr   = 1'b0;

        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.data_in;
                    pc_d    = pc + ADDR_W'(1);
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (exec_fire) begin
                    state_d = S_FETCH;
                    // Branch conditions use z/c as they stood before this instruction.
                    case (opcode)
                        OP_ADD: begin
                            ac_new = add_full[DATA_W-1:0];
                            ac_wr  = 1'b1;
                            c_d    = add_full[DATA_W];
                        end
                        OP_SHL: begin
                            ac_new = shl_res;
                            ac_wr  = 1'b1;
                        end
                        OP_SHR: begin
                            ac_new = shr_res;
                            ac_wr  = 1'b1;
                        end
                        OP_LDI: begin
                            ac_new = {{(DATA_W-ADDR_W){1'b0}}, operand};
                            ac_wr  = 1'b1;
                        end
                        OP_LD: begin
                            ac_new = m;
                            ac_wr  = 1'b1;
                        end
                        OP_OR: begin
                            ac_new = ac | m;
                            ac_wr  = 1'b1;
                        end
                        OP_AND: begin
                            ac_new = ac & m;
                            ac_wr  = 1'b1;
                        end
                        OP_SUB: begin
                            ac_new = sub_res;
                            ac_wr  = 1'b1;
                            c_d    = sub_borrow;
                        end
                        OP_XOR: begin
                            ac_new = ac ^ m;
                            ac_wr  = 1'b1;
                        end
                        OP_BR: pc_d = operand;
                        OP_BZ: if (z) pc_d = operand;
                        OP_BC: if (c) pc_d = operand;
                        OP_HALT: state_d = S_HALT;
                        default: ; // NOP, ST and the reserved opcode leave registers alone
                    endcase

                    if (ac_wr) begin
                        ac_d = ac_new;
                        z_d  = (ac_new == '0);
                    end
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    assign bus.data_out = ac;
    assign bus.address  = (state == S_EXECUTE) ? operand : pc;
    assign bus.we       = (state == S_EXECUTE) && (opcode == OP_ST);
    assign bus.mem_req  = (state == S_FETCH) || ((state == S_EXECUTE) && is_mem_op);
    assign bus.halted   = (state == S_HALT);

    assign bus.dbg_state = state;
    assign bus.dbg_pc    = pc;
    assign bus.dbg_ir    = ir;
    assign bus.dbg_z     = z;
    assign bus.dbg_c     = c;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: a 32/16 instance and a 16/8 instance, each backed
// by a small word memory that honours the ready/request handshake.
module tb_acc_cpu_param;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  acc_cpu_param_if #(.DATA_W(32), .ADDR_W(16)) bus_a ();
  acc_cpu_param_if #(.DATA_W(16), .ADDR_W(8))  bus_b ();

  acc_cpu_param #(.DATA_W(32), .ADDR_W(16)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  acc_cpu_param #(.DATA_W(16), .ADDR_W(8))  dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  assign bus_a.data_in = mem_a[bus_a.address[7:0]];
  assign bus_b.data_in = mem_b[bus_b.address];

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ia(input logic [3:0] op, input logic [15:0] a);
    return {op, 12'h000, a};
  endfunction

  function automatic logic [15:0] ib(input logic [3:0] op, input logic [7:0] a);
    return {op, 4'h0, a};
  endfunction

  // One clock edge; stores are committed on the edge where we and mem_ready are both high.
  task automatic tick();
    logic        st_a;
    logic [7:0]  ad_a;
    logic [31:0] dt_a;
    logic        st_b;
    logic [7:0]  ad_b;
    logic [15:0] dt_b;
    @(negedge clock);
    st_a = bus_a.we && bus_a.mem_ready;
    ad_a = bus_a.address[7:0];
    dt_a = bus_a.data_out;
    st_b = bus_b.we && bus_b.mem_ready;
    ad_b = bus_b.address;
    dt_b = bus_b.data_out;
    @(posedge clock);
    if (st_a) mem_a[ad_a] = dt_a;
    if (st_b) mem_b[ad_b] = dt_b;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 16'h0;
    end
  endtask

  // After this returns, the next edge is the first fetch edge.
  task automatic start_run();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    bus_a.mem_ready = 1'b1;
    reset = 1'b0;
    ticks(2);
    checks++; if (bus_a.address !== 16'h0) begin errors++; $display("FAIL rst_address got %h exp %h", bus_a.address, 16'h0); end
    checks++; if (bus_a.data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out got %h exp %h", bus_a.data_out, 32'h0); end
    checks++; if (bus_a.we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus_a.we); end
    checks++; if (bus_a.mem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_req got %b exp 1", bus_a.mem_req); end
    checks++; if (bus_a.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", bus_a.halted); end
    checks++; if (bus_a.dbg_z !== 1'b1 || bus_a.dbg_c !== 1'b0) begin errors++; $display("FAIL rst_flags got z%b c%b exp z1 c0", bus_a.dbg_z, bus_a.dbg_c); end
    checks++; if (bus_a.dbg_ir !== 32'h0 || bus_a.dbg_pc !== 16'h0) begin errors++; $display("FAIL rst_ir_pc got %h %h exp 0 0", bus_a.dbg_ir, bus_a.dbg_pc); end
  endtask

  task automatic test_program();
    clear_mem();
    mem_a[0] = ia(4'b0100, 16'h0005);
    mem_a[1] = ia(4'b0001, 16'h0030);
    mem_a[2] = ia(4'b0111, 16'h0031);
    mem_a[3] = ia(4'b1111, 16'h0000);
    mem_a[8'h30] = 32'd7;
    bus_a.mem_ready = 1'b1;
    start_run();
    ticks(5);
    checks++; if (bus_a.we !== 1'b1 || bus_a.address !== 16'h0031) begin errors++; $display("FAIL prog_st_drive got we%b %h exp we1 0031", bus_a.we, bus_a.address); end
    checks++; if (mem_a[8'h31] !== 32'h0) begin errors++; $display("FAIL prog_st_early got %h exp %h", mem_a[8'h31], 32'h0); end
    tick();
    checks++; if (mem_a[8'h31] !== 32'd12) begin errors++; $display("FAIL prog_st_value got %h exp %h", mem_a[8'h31], 32'd12); end
    tick();
    checks++; if (bus_a.halted !== 1'b0) begin errors++; $display("FAIL prog_halt_early got %b exp 0", bus_a.halted); end
    tick();
    checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL prog_halted got %b exp 1", bus_a.halted); end
    checks++; if (bus_a.mem_req !== 1'b0 || bus_a.we !== 1'b0) begin errors++; $display("FAIL prog_halt_bus got req%b we%b exp 0 0", bus_a.mem_req, bus_a.we); end
    checks++; if (bus_a.data_out !== 32'd12) begin errors++; $display("FAIL prog_ac got %h exp %h", bus_a.data_out, 32'd12); end
    checks++; if (bus_a.dbg_z !== 1'b0 || bus_a.dbg_c !== 1'b0) begin errors++; $display("FAIL prog_flags got z%b c%b exp z0 c0", bus_a.dbg_z, bus_a.dbg_c); end
    ticks(3);
    checks++; if (bus_a.halted !== 1'b1 || bus_a.address !== 16'h0004) begin errors++; $display("FAIL prog_halt_sticky got h%b %h exp h1 0004", bus_a.halted, bus_a.address); end
  endtask

  task automatic test_sub_branch();
    clear_mem();
    mem_a[0] = ia(4'b0100, 16'h0003);
    mem_a[1] = ia(4'b1010, 16'h0030);
    mem_a[2] = ia(4'b1101, 16'h0020);
    mem_a[8'h20] = ia(4'b1100, 16'h0040);
    mem_a[8'h21] = ia(4'b1111, 16'h0000);
    mem_a[8'h30] = 32'd5;
    bus_a.mem_ready = 1'b1;
    start_run();
    ticks(4);
    checks++; if (bus_a.data_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_ac got %h exp %h", bus_a.data_out, 32'hFFFF_FFFE); end
    checks++; if (bus_a.dbg_c !== 1'b1 || bus_a.dbg_z !== 1'b0) begin errors++; $display("FAIL sub_flags got z%b c%b exp z0 c1", bus_a.dbg_z, bus_a.dbg_c); end
    ticks(2);
    checks++; if (bus_a.address !== 16'h0020 || bus_a.mem_req !== 1'b1) begin errors++; $display("FAIL bc_taken got %h req%b exp 0020 req1", bus_a.address, bus_a.mem_req); end
    ticks(2);
    checks++; if (bus_a.address !== 16'h0021) begin errors++; $display("FAIL bz_not_taken got %h exp %h", bus_a.address, 16'h0021); end
    ticks(2);
    checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL sub_halted got %b exp 1", bus_a.halted); end
  endtask

  task automatic test_add_carry();
    clear_mem();
    mem_a[0] = ia(4'b0101, 16'h0030);
    mem_a[1] = ia(4'b0001, 16'h0031);
    mem_a[2] = ia(4'b1100, 16'h0010);
    mem_a[8'h10] = ia(4'b1101, 16'h0018);
    mem_a[8'h18] = ia(4'b1111, 16'h0000);
    mem_a[8'h30] = 32'hFFFF_FFFF;
    mem_a[8'h31] = 32'h0000_0001;
    bus_a.mem_ready = 1'b1;
    start_run();
    ticks(4);
    checks++; if (bus_a.data_out !== 32'h0) begin errors++; $display("FAIL add_wrap got %h exp %h", bus_a.data_out, 32'h0); end
    checks++; if (bus_a.dbg_c !== 1'b1 || bus_a.dbg_z !== 1'b1) begin errors++; $display("FAIL add_flags got z%b c%b exp z1 c1", bus_a.dbg_z, bus_a.dbg_c); end
    ticks(2);
    checks++; if (bus_a.address !== 16'h0010) begin errors++; $display("FAIL bz_taken got %h exp %h", bus_a.address, 16'h0010); end
    ticks(2);
    checks++; if (bus_a.address !== 16'h0018) begin errors++; $display("FAIL bc_after_add got %h exp %h", bus_a.address, 16'h0018); end
  endtask

  task automatic test_waits();
    clear_mem();
    mem_a[0] = ia(4'b0101, 16'h0030);
    mem_a[8'h30] = 32'hDEAD_BEEF;
    bus_a.mem_ready = 1'b0;
    start_run();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus_a.address !== 16'h0 || bus_a.dbg_pc !== 16'h0 || bus_a.dbg_ir !== 32'h0 || bus_a.data_out !== 32'h0) begin errors++; $display("FAIL wait_fetch_%0d got a%h pc%h ir%h ac%h exp all 0", i, bus_a.address, bus_a.dbg_pc, bus_a.dbg_ir, bus_a.data_out); end
    end
    bus_a.mem_ready = 1'b1;
    tick();
    checks++; if (bus_a.dbg_ir !== 32'h5000_0030 || bus_a.dbg_pc !== 16'h1 || bus_a.address !== 16'h0030) begin errors++; $display("FAIL wait_fetched got ir%h pc%h a%h exp 50000030 0001 0030", bus_a.dbg_ir, bus_a.dbg_pc, bus_a.address); end
    bus_a.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus_a.data_out !== 32'h0 || bus_a.address !== 16'h0030 || bus_a.dbg_pc !== 16'h1 || bus_a.dbg_state !== 2'd1) begin errors++; $display("FAIL wait_exec_%0d got ac%h a%h pc%h st%0d exp 0 0030 0001 1", i, bus_a.data_out, bus_a.address, bus_a.dbg_pc, bus_a.dbg_state); end
    end
    bus_a.mem_ready = 1'b1;
    tick();
    checks++; if (bus_a.data_out !== 32'hDEAD_BEEF || bus_a.dbg_state !== 2'd0 || bus_a.address !== 16'h1) begin errors++; $display("FAIL wait_done got ac%h st%0d a%h exp deadbeef 0 0001", bus_a.data_out, bus_a.dbg_state, bus_a.address); end
  endtask

  task automatic test_shifts();
    clear_mem();
    mem_a[0] = ia(4'b0101, 16'h0030);
    mem_a[1] = ia(4'b0010, 16'h0031);
    mem_a[2] = ia(4'b0011, 16'h0032);
    mem_a[3] = ia(4'b1110, 16'h0033);
    mem_a[8'h30] = 32'h8000_0001;
    mem_a[8'h31] = 32'd1;
    mem_a[8'h32] = 32'd32;
    mem_a[8'h33] = 32'h1234_5678;
    bus_a.mem_ready = 1'b1;
    start_run();
    ticks(4);
    checks++; if (bus_a.data_out !== 32'h0000_0002 || bus_a.dbg_z !== 1'b0) begin errors++; $display("FAIL shl_one got %h z%b exp 00000002 z0", bus_a.data_out, bus_a.dbg_z); end
    ticks(2);
    checks++; if (bus_a.data_out !== 32'h0 || bus_a.dbg_z !== 1'b1) begin errors++; $display("FAIL shr_full got %h z%b exp 00000000 z1", bus_a.data_out, bus_a.dbg_z); end
    ticks(2);
    checks++; if (bus_a.dbg_pc !== 16'h4 || bus_a.data_out !== 32'h0 || bus_a.dbg_z !== 1'b1 || bus_a.dbg_c !== 1'b0) begin errors++; $display("FAIL reserved_op got pc%h ac%h z%b c%b exp 0004 0 z1 c0", bus_a.dbg_pc, bus_a.data_out, bus_a.dbg_z, bus_a.dbg_c); end
    checks++; if (bus_a.address !== 16'h4) begin errors++; $display("FAIL reserved_next got %h exp %h", bus_a.address, 16'h4); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem_b[0] = 16'h40AB;
    mem_b[1] = ib(4'b1000, 8'hFF);
    mem_b[255] = 16'h0000;
    bus_b.mem_ready = 1'b1;
    start_run();
    ticks(2);
    checks++; if (bus_b.data_out !== 16'h00AB || bus_b.dbg_z !== 1'b0) begin errors++; $display("FAIL narrow_ldi got %h z%b exp 00ab z0", bus_b.data_out, bus_b.dbg_z); end
    ticks(2);
    checks++; if (bus_b.address !== 8'hFF) begin errors++; $display("FAIL narrow_br got %h exp %h", bus_b.address, 8'hFF); end
    tick();
    checks++; if (bus_b.dbg_pc !== 8'h00) begin errors++; $display("FAIL pc_wrap got %h exp %h", bus_b.dbg_pc, 8'h00); end
    tick();
    checks++; if (bus_b.address !== 8'h00 || bus_b.mem_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch got %h req%b exp 00 req1", bus_b.address, bus_b.mem_req); end
  endtask

  task automatic test_reset_mid_st();
    clear_mem();
    mem_a[0] = ia(4'b0100, 16'h0009);
    mem_a[1] = ia(4'b0111, 16'h0031);
    mem_a[8'h31] = 32'h55;
    bus_a.mem_ready = 1'b1;
    start_run();
    ticks(3);
    bus_a.mem_ready = 1'b0;
    tick();
    checks++; if (bus_a.we !== 1'b1 || bus_a.data_out !== 32'd9 || bus_a.address !== 16'h0031) begin errors++; $display("FAIL st_wait got we%b ac%h a%h exp we1 9 0031", bus_a.we, bus_a.data_out, bus_a.address); end
    reset = 1'b0;
    #1;
    checks++; if (bus_a.we !== 1'b0) begin errors++; $display("FAIL abort_we got %b exp 0", bus_a.we); end
    checks++; if (bus_a.address !== 16'h0 || bus_a.data_out !== 32'h0 || bus_a.mem_req !== 1'b1) begin errors++; $display("FAIL abort_bus got a%h ac%h req%b exp 0 0 1", bus_a.address, bus_a.data_out, bus_a.mem_req); end
    bus_a.mem_ready = 1'b1;
    tick();
    checks++; if (mem_a[8'h31] !== 32'h55) begin errors++; $display("FAIL abort_mem got %h exp %h", mem_a[8'h31], 32'h55); end
    reset = 1'b1;
    checks++; if (bus_a.address !== 16'h0 || bus_a.data_out !== 32'h0) begin errors++; $display("FAIL post_reset got a%h ac%h exp 0 0", bus_a.address, bus_a.data_out); end
    tick();
    checks++; if (bus_a.dbg_ir !== 32'h4000_0009 || bus_a.dbg_pc !== 16'h1) begin errors++; $display("FAIL post_reset_fetch got ir%h pc%h exp 40000009 0001", bus_a.dbg_ir, bus_a.dbg_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus_a.mem_ready = 1'b1;
    bus_b.mem_ready = 1'b1;
    test_reset();
    test_program();
    test_sub_branch();
    test_add_carry();
    test_waits();
    test_shifts();
    test_wrap();
    test_reset_mid_st();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
# acc_cpu_param

Parametrised accumulator CPU: next generation of the team's 4-bit-opcode, fetch/execute accumulator core. It adds configurable data/address width, a ready/request memory handshake with wait states, Z/C flags, SUB/XOR, conditional branches and HALT. It is opcode-compatible with the existing core for opcodes 0001–1001, and sits between the program/data memory and nothing else. It is the sole bus master.

## Interface
- DATA_W, 32, accumulator/memory word width; must be ≥ ADDR_W+4
- ADDR_W, 16, address width; PC width and instruction operand field width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  read data (instruction or operand)
- mem_ready  in  1  memory completes current transfer at this edge
- data_out  out  DATA_W  always equals AC
- address  out  ADDR_W  FETCH: PC; EXECUTE: IR[ADDR_W-1:0]; HALT: PC
- we  out  1  write strobe: EXECUTE & opcode ST
- mem_req  out  1  transfer request, combinational from state and opcode
- halted  out  1  high in HALT state

## Operation
- Instruction: opcode = IR[DATA_W-1:DATA_W-4], operand A = IR[ADDR_W-1:0], other bits ignored. M = data_in during execute.
- States: FETCH, EXECUTE, HALT.
- FETCH: mem_req=1, address=PC. On an edge with mem_ready=1: IR<=data_in, PC<=PC+1 (mod 2^ADDR_W), go to EXECUTE. Otherwise hold.
- EXECUTE, memory ops (ADD, SHL, SHR, LD, OR, ST, AND, SUB, XOR): mem_req=1. The op completes on the edge with mem_ready=1, then FETCH. Otherwise hold, with no register change.
- EXECUTE, non-memory ops: mem_req=0. The op completes on the next edge regardless of mem_ready.
- Opcodes:
  - 0000 NOP.
  - 0001 ADD: AC<=AC+M, C<=carry-out.
  - 0010 SHL: AC<=AC<<M, logical; M≥DATA_W gives 0.
  - 0011 SHR: AC<=AC>>M, logical; M≥DATA_W gives 0.
  - 0100 LDI: AC<=zero-extended A.
  - 0101 LD: AC<=M.
  - 0110 OR: AC<=AC|M.
  - 0111 ST: memory[A]<=AC via we.
  - 1000 BR: PC<=A.
  - 1001 AND: AC<=AC&M.
  - 1010 SUB: AC<=AC−M mod 2^DATA_W, C<=1 iff M>AC unsigned (borrow).
  - 1011 XOR: AC<=AC^M.
  - 1100 BZ: PC<=A if Z.
  - 1101 BC: PC<=A if C.
  - 1110 reserved, behaves as NOP.
  - 1111 HALT: go to HALT.
- Flags:
  - Z<=(new AC==0) on every AC write (ADD, SHL, SHR, LDI, LD, OR, AND, SUB, XOR).
  - C is written only by ADD and SUB.
  - Branches read the flag values from before the current instruction.
- HALT: mem_req=0, we=0, halted=1. Left only by reset.

## Timing
- Reset values (asynchronous, apply immediately while reset=0): state FETCH, PC=0, IR=0, AC=0, Z=1, C=0. Resulting outputs: address=0, data_out=0, we=0, mem_req=1, halted=0. mem_ready is ignored while in reset.
- Reset asserted mid-transfer aborts it: we falls combinationally in the same cycle, and there is no partial register update.
- With mem_ready tied 1, every instruction takes exactly 2 cycles: one fetch edge plus one execute edge. This matches the previous core's cadence.
- Each wait cycle (mem_ready=0 while mem_req=1) adds exactly 1 cycle. address, we and data_out stay stable throughout the wait.
- A store is committed by memory on the edge where we=1 and mem_ready=1. we stays high for the whole ST execute, including waits.
- PC increment wraps: PC=2^ADDR_W−1 fetch gives PC=0.
- A branch target is fetched on the cycle after the branch executes.
- Back-to-back: the FETCH for the next instruction starts on the cycle immediately after execute completes. There are no idle cycles.

## Test plan
- mem_ready=1; program: LDI 5; ADD [x]=7; ST [y]; HALT → mem[y]=12 written at cycle 6. halted=1 from cycle 8. AC=12, Z=0, C=0.
- SUB: AC=3, M=5 → AC=0xFFFFFFFE, C=1, Z=0. The following BC 0x20 fetches from address 0x20. A following BZ 0x40 is not taken.
- Waits: mem_ready low for 3 cycles on the fetch and 2 cycles on an LD execute → the instruction takes 7 cycles. IR, PC and AC are unchanged during waits; address is stable.
- Shifts: AC=0x80000001. SHL with M=1 → 0x00000002. SHR with M=32 → 0, Z=1. Reserved opcode 1110 → no state change except PC+1.
- Parameters DATA_W=16, ADDR_W=8: PC=0xFF fetch wraps to 0. LDI with IR=0x40AB → AC=0x00AB.
- Assert reset mid-ST while mem_ready=0 → we=0 immediately, memory unchanged. After release, the first fetch is from address 0 and AC=0.
